// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, config type and operand clamp for clock_divider_multi
package clkdiv_pkg;

  localparam int DEFAULT_DIV  = 500;
  localparam int DEFAULT_HIGH = 250;

  // Widest counter any instance may use; channels truncate to their own CNT_W.
  localparam int MAX_CNT_W = 64;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] div;
    logic [MAX_CNT_W-1:0] high;
  } chan_cfg_t;

  // Divisor is at least 2 and high time at most one less than the divisor,
  // so a clamped pair always produces both a high and a low phase (unless high=0).
  function automatic chan_cfg_t clamp_cfg(input logic [MAX_CNT_W-1:0] div,
                                          input logic [MAX_CNT_W-1:0] high);
    chan_cfg_t c;
    c.div  = (div < 64'd2) ? 64'd2 : div;
    c.high = (high > c.div - 64'd1) ? c.div - 64'd1 : high;
    return c;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel: counter, shadow config and registered outputs
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int DEF_DIV  = 500,
  parameter int DEF_HIGH = 250
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_align,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_pending,
  output logic             o_clk,
  output logic             o_tick
);

  localparam chan_cfg_t        RST_CFG  = clamp_cfg(MAX_CNT_W'(DEF_DIV), MAX_CNT_W'(DEF_HIGH));
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(RST_CFG.div);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(RST_CFG.high);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_sh_div;
  logic [CNT_W-1:0] r_sh_high;
  logic             r_pending;
  logic             r_clk;
  logic             r_tick;

  chan_cfg_t        w_ld;
  logic             w_wrap;
  logic             w_apply;

  assign w_ld    = clamp_cfg(MAX_CNT_W'(i_div), MAX_CNT_W'(i_high));
  assign w_wrap  = (r_count == r_div - ONE);
  // A running channel only swaps config on a wrap so the current period is never cut short.
  assign w_apply = r_pending & (i_align | ~i_en | w_wrap);

  // Counter and active config: wrap, apply pending update, or forced alignment to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_div   <= RST_DIV;
      r_high  <= RST_HIGH;
    end else begin
      if (w_apply) begin
        r_div  <= r_sh_div;
        r_high <= r_sh_high;
      end
      if (i_align || w_apply) begin
        r_count <= '0;
      end else if (i_en) begin
        r_count <= w_wrap ? '0 : r_count + ONE;
      end
    end
  end

  // Shadow registers capture a clamped request; apply releases the slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_sh_div  <= RST_DIV;
      r_sh_high <= RST_HIGH;
    end else if (i_load) begin
      r_pending <= 1'b1;
      r_sh_div  <= CNT_W'(w_ld.div);
      r_sh_high <= CNT_W'(w_ld.high);
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // Registered divided clock and tick; a disabled channel freezes its clock and silences tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      r_clk  <= (r_count < r_high);
      r_tick <= (r_count == '0);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_clk     = r_clk;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable clock divider (optional CLKDIV_PHASE_ALIGN_EN)
module clock_divider_multi #(
  parameter int  NUM_CH       = 2,
  parameter int  CNT_W        = 32,
  parameter int  DEFAULT_DIV  = clkdiv_pkg::DEFAULT_DIV,
  parameter int  DEFAULT_HIGH = clkdiv_pkg::DEFAULT_HIGH,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk_in,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  input  logic [CNT_W-1:0]  i_cfg_high,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic              i_align_req,
`endif
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick
);

  localparam int SLOTS = 1 << CH_W;

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_load;
  logic [SLOTS-1:0]  w_ready_slot;
  logic              w_align;

`ifdef CLKDIV_PHASE_ALIGN_EN
  assign w_align = i_align_req;
`else
  assign w_align = 1'b0;
`endif

  // Ready per address slot; slots past NUM_CH stay ready so stray writes are swallowed.
  always_comb begin
    w_ready_slot = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ready_slot[i] = ~w_pending[i];
    end
  end

  assign o_cfg_ready = w_ready_slot[i_cfg_ch];

  // Decode an accepted transfer onto the addressed channel's load strobe.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_load[i] = i_cfg_valid & o_cfg_ready & (i_cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEFAULT_DIV),
      .DEF_HIGH(DEFAULT_HIGH)
    ) u_ch (
      .i_clk    (i_clk_in),
      .i_rst    (i_rst),
      .i_en     (i_en[g]),
      .i_load   (w_load[g]),
      .i_align  (w_align),
      .i_div    (i_cfg_div),
      .i_high   (i_cfg_high),
      .o_pending(w_pending[g]),
      .o_clk    (o_clk_out[g]),
      .o_tick   (o_tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - directed self-checking bench for clock_divider_multi
module tb_clock_divider_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [31:0] cfg_high;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
`ifdef CLKDIV_PHASE_ALIGN_EN
  logic        align_req;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_divider_multi dut (
    .i_clk_in   (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_div  (cfg_div),
    .i_cfg_high (cfg_high),
`ifdef CLKDIV_PHASE_ALIGN_EN
    .i_align_req(align_req),
`endif
    .o_clk_out  (clk_out),
    .o_tick     (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    int n;
    cfg_ch   = ch[0:0];
    cfg_div  = dv;
    cfg_high = hi;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_write_ready ch%0d: cfg_ready=%b after %0d cycles, required 1", ch, cfg_ready, n);
    end
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input int ch);
    int n;
    cfg_ch = ch[0:0];
    n = 0;
    while (cfg_ready !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready ch%0d: cfg_ready=%b after %0d cycles, required 1", ch, cfg_ready, n);
    end
  endtask

  // Starting at the next (or current) tick, observe one full period.
  task automatic measure(input int ch, input int per, input int hi, input string name);
    int n, hi_cnt, tk;
    n = 0;
    while (tick[ch] !== 1'b1 && n < 1100) begin
      step();
      n++;
    end
    checks++;
    if (tick[ch] !== 1'b1) begin
      errors++;
      $display("FAIL %s tick_timeout: no tick in %0d cycles, required a tick", name, n);
    end else begin
      checks++;
      if (clk_out[ch] !== (hi > 0)) begin
        errors++;
        $display("FAIL %s rise_with_tick: clk_out=%b, required %0d", name, clk_out[ch], hi > 0);
      end
      hi_cnt = 0;
      tk = 0;
      for (int k = 0; k < per; k++) begin
        hi_cnt += int'(clk_out[ch]);
        tk += int'(tick[ch]);
        step();
      end
      checks++;
      if (hi_cnt != hi) begin
        errors++;
        $display("FAIL %s high_cycles: got %0d, required %0d", name, hi_cnt, hi);
      end
      checks++;
      if (tk != 1) begin
        errors++;
        $display("FAIL %s ticks_per_period: got %0d, required 1", name, tk);
      end
      checks++;
      if (tick[ch] !== 1'b1) begin
        errors++;
        $display("FAIL %s period: no tick after %0d cycles, required tick", name, per);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b01; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0; cfg_high = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    align_req = 1'b0;
`endif
    step();
    step();
    checks++;
    if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out: got %b, required 00", clk_out); end
    checks++;
    if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b, required 00", tick); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
    rst = 1'b0;
    step();
    checks++;
    if (tick !== 2'b01) begin errors++; $display("FAIL first_tick: got %b, required 01", tick); end
    checks++;
    if (clk_out !== 2'b01) begin errors++; $display("FAIL first_clk_out: got %b, required 01", clk_out); end
    measure(0, 500, 250, "default_period");
  endtask

  task automatic test_reprogram();
    int n, rdy_at;
    cfg_write(0, 10, 3);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reprog_pending_ready: got %b, required 0", cfg_ready); end
    n = 0;
    rdy_at = -1;
    while (tick[0] !== 1'b1 && n < 1100) begin
      if (cfg_ready === 1'b1 && rdy_at < 0) rdy_at = n;
      step();
      n++;
    end
    checks++;
    if (n != 499) begin errors++; $display("FAIL reprog_old_period_end: tick after %0d cycles, required 499", n); end
    checks++;
    if (rdy_at != 498) begin errors++; $display("FAIL reprog_ready_at_apply: ready at %0d, required 498", rdy_at); end
    measure(0, 10, 3, "reprog_div10");
  endtask

  task automatic test_clamp();
    cfg_write(0, 1, 7);
    wait_ready(0);
    measure(0, 2, 1, "clamp_div1_high7");
    cfg_write(0, 8, 0);
    wait_ready(0);
    measure(0, 8, 0, "clamp_high0");
  endtask

  task automatic test_back_to_back();
    int stall;
    cfg_ch = 1'b1; cfg_div = 6; cfg_high = 3;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b, required 1", cfg_ready); end
    en = 2'b11;
    cfg_valid = 1'b1;
    step();
    cfg_div = 4; cfg_high = 1;
    stall = 0;
    while (cfg_ready !== 1'b1 && stall < 1100) begin
      stall++;
      step();
    end
    checks++;
    if (stall != 499) begin errors++; $display("FAIL b2b_stall: stalled %0d cycles, required 499", stall); end
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_pending: ready=%b, required 0", cfg_ready); end
    measure(1, 6, 3, "b2b_first_value");
    measure(1, 4, 1, "b2b_second_value");
  endtask

  task automatic test_enable();
    int bad_tick, bad_clk, n;
    cfg_write(0, 10, 5);
    wait_ready(0);
    measure(0, 10, 5, "en_setup");
    step(); step(); step();
    en = 2'b10;
    bad_tick = 0;
    bad_clk = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (tick[0] !== 1'b0) bad_tick++;
      if (clk_out[0] !== 1'b1) bad_clk++;
    end
    checks++;
    if (bad_tick != 0) begin errors++; $display("FAIL disabled_tick: %0d cycles with tick, required 0", bad_tick); end
    checks++;
    if (bad_clk != 0) begin errors++; $display("FAIL disabled_clk_hold: %0d cycles not held at 1, required 0", bad_clk); end
    en = 2'b11;
    n = 0;
    do begin
      step();
      n++;
    end while (tick[0] !== 1'b1 && n < 1100);
    checks++;
    if (n != 7) begin errors++; $display("FAIL resume_from_count4: tick after %0d cycles, required 7", n); end
  endtask

  task automatic test_reset_mid_pending();
    cfg_write(0, 4, 2);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending_ready: got %b, required 0", cfg_ready); end
    rst = 1'b1;
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b, required 1", cfg_ready); end
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_outputs: clk_out=%b tick=%b, required 00 00", clk_out, tick);
    end
    rst = 1'b0;
    measure(0, 500, 250, "post_reset_default");
  endtask

`ifdef CLKDIV_PHASE_ALIGN_EN
  task automatic test_align();
    int n_both;
    cfg_write(0, 6, 3);
    wait_ready(0);
    cfg_write(1, 4, 2);
    wait_ready(1);
    align_req = 1'b1;
    step();
    align_req = 1'b0;
    step();
    checks++;
    if (tick !== 2'b11) begin errors++; $display("FAIL align_first_tick: got %b, required 11", tick); end
    n_both = 0;
    for (int k = 0; k < 11; k++) begin
      step();
      if (tick === 2'b11) n_both++;
    end
    checks++;
    if (n_both != 0) begin errors++; $display("FAIL align_early_coincide: %0d, required 0", n_both); end
    step();
    checks++;
    if (tick !== 2'b11) begin errors++; $display("FAIL align_lcm_tick: got %b, required 11", tick); end
  endtask
`endif

  initial begin
    test_reset();
    test_reprogram();
    test_clamp();
    test_back_to_back();
    test_enable();
    test_reset_mid_pending();
`ifdef CLKDIV_PHASE_ALIGN_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
